serial_channel_packer: RTL and testbench

- Downstream stage of the serial frame controller: consumes the demultiplexed payload stream, one bit per cycle, while that controller asserts its output-valid.
- Packs payload bits per frame into bytes, MSB-first, and tags each byte with its channel, bit count and last-of-frame flag.
- Buffers the tagged bytes in a small FIFO behind a valid/ready handshake to the consumer.
- Owns frame delimiting (valid fall or channel change), partial-byte flush and overflow reporting.

---
 rtl/serial_channel_packer.sv | 137 +++++++++++++
 tb/tb_serial_channel_packer.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/serial_channel_packer.sv
// serial_channel_packer: packs a framed serial payload stream into channel-tagged bytes behind a small FIFO.
//   clk, rst         clock (rising edge) and asynchronous active-high reset
//   in_valid/in_bit  payload bit stream, one bit per cycle while in_valid=1
//   in_chan          channel of the current frame
//   out_ready        consumer takes the head entry when out_valid=1
//   clr_ovf          clears the sticky overflow flag
//   out_valid/out_*  FIFO head: right-aligned byte, channel, bit count, last-of-frame
//   ovf              sticky drop indicator
//   frame_cnt        completed frames, wrapping
module serial_channel_packer #(
   parameter int DEPTH = 4,
   parameter int PTR_W = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       in_valid,
   input  logic       in_bit,
   input  logic [1:0] in_chan,
   input  logic       out_ready,
   input  logic       clr_ovf,
   output logic       out_valid,
   output logic [7:0] out_data,
   output logic [1:0] out_chan,
   output logic [3:0] out_nbits,
   output logic       out_last,
   output logic       ovf,
   output logic [7:0] frame_cnt
);
   typedef struct packed {
      logic [7:0] data;
      logic [1:0] chan;
      logic [3:0] nbits;
      logic       last;
   } entry_t;

   localparam logic [PTR_W:0] FULL = (PTR_W+1)'(DEPTH);
   localparam logic [PTR_W:0] ONE  = (PTR_W+1)'(1);

   logic [7:0]     acc_q, acc_d;
   logic [3:0]     cnt_q, cnt_d;
   logic [1:0]     chan_q, chan_d;
   logic           prev_valid_q, prev_valid_d;
   logic [7:0]     frame_cnt_q, frame_cnt_d;
   logic [PTR_W:0] wp_q, wp_d, rp_q, rp_d, occ, pop_w;
   entry_t         mem_q [DEPTH];
   entry_t         mem_d [DEPTH];
   entry_t         head_q, head_d, ent;
   logic           out_valid_q, out_valid_d, ovf_q, ovf_d;
   logic           push, pop, accept;

   always_comb begin
      acc_d = acc_q;
      cnt_d = cnt_q;
      chan_d = chan_q;
      prev_valid_d = in_valid;
      frame_cnt_d = frame_cnt_q;
      push = 1'b0;
      ent = '0;
      if (in_valid) begin
         // a channel switch mid-frame closes the old frame and opens a new one on the same edge
         if (cnt_q != 4'd0 && in_chan != chan_q) begin
            push = 1'b1;
            ent = {acc_q, chan_q, cnt_q, 1'b1};
            frame_cnt_d = frame_cnt_q + 8'd1;
         end else if (cnt_q == 4'd8) begin
            push = 1'b1;
            ent = {acc_q, chan_q, 4'd8, 1'b0};
         end
         // restarting from zero keeps the bits above nbits clear
         if (push || cnt_q == 4'd0) begin
            acc_d = {7'b0, in_bit};
            cnt_d = 4'd1;
            chan_d = in_chan;
         end else begin
            acc_d = {acc_q[6:0], in_bit};
            cnt_d = cnt_q + 4'd1;
         end
      end else if (prev_valid_q && cnt_q != 4'd0) begin
         push = 1'b1;
         ent = {acc_q, chan_q, cnt_q, 1'b1};
         cnt_d = 4'd0;
         frame_cnt_d = frame_cnt_q + 8'd1;
      end
      pop = out_valid_q & out_ready;
      pop_w = {{PTR_W{1'b0}}, pop};
      occ = wp_q - rp_q;
      accept = push && (occ != FULL || pop);
      mem_d = mem_q;
      wp_d = wp_q;
      if (accept) begin
         mem_d[wp_q[PTR_W-1:0]] = ent;
         wp_d = wp_q + ONE;
      end
      rp_d = rp_q + pop_w;
      // only entries already stored before this edge become visible, giving one cycle of push latency
      out_valid_d = (occ - pop_w) != '0;
      head_d = out_valid_d ? mem_q[rp_d[PTR_W-1:0]] : head_q;
      ovf_d = (push & ~accept) | (ovf_q & ~clr_ovf);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         acc_q <= '0;
         cnt_q <= '0;
         chan_q <= '0;
         prev_valid_q <= 1'b0;
         frame_cnt_q <= '0;
         wp_q <= '0;
         rp_q <= '0;
         head_q <= '0;
         out_valid_q <= 1'b0;
         ovf_q <= 1'b0;
      end else begin
         acc_q <= acc_d;
         cnt_q <= cnt_d;
         chan_q <= chan_d;
         prev_valid_q <= prev_valid_d;
         frame_cnt_q <= frame_cnt_d;
         wp_q <= wp_d;
         rp_q <= rp_d;
         head_q <= head_d;
         out_valid_q <= out_valid_d;
         ovf_q <= ovf_d;
      end
   end

   // storage needs no reset: it is never read until written
   always_ff @(posedge clk) mem_q <= mem_d;

   assign out_valid = out_valid_q;
   assign out_data  = head_q.data;
   assign out_chan  = head_q.chan;
   assign out_nbits = head_q.nbits;
   assign out_last  = head_q.last;
   assign ovf       = ovf_q;
   assign frame_cnt = frame_cnt_q;
endmodule

// File: tb/tb_serial_channel_packer.sv
// tb_serial_channel_packer: vector table, directed corner sequences and random traffic against a frame-level model.
module tb_serial_channel_packer;
   localparam int DEPTH = 4;

   typedef struct packed {
      logic [7:0] d;
      logic [1:0] c;
      logic [3:0] n;
      logic       l;
   } ent_t;

   typedef struct packed {
      logic       v;
      ent_t       e;
      logic       o;
      logic [7:0] f;
   } obs_t;

   typedef struct {
      logic       v, b;
      logic [1:0] c;
      logic       r;
      obs_t       x;
   } vec_t;

   logic clk = 1'b0, rst = 1'b1, in_valid = 1'b0, in_bit = 1'b0, out_ready = 1'b0, clr_ovf = 1'b0;
   logic [1:0] in_chan = 2'd0;
   logic out_valid, out_last, ovf;
   logic [7:0] out_data, frame_cnt;
   logic [1:0] out_chan;
   logic [3:0] out_nbits;

   always #5 clk = ~clk;

   serial_channel_packer #(.DEPTH(DEPTH), .PTR_W(2)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_bit(in_bit), .in_chan(in_chan),
      .out_ready(out_ready), .clr_ovf(clr_ovf), .out_valid(out_valid), .out_data(out_data),
      .out_chan(out_chan), .out_nbits(out_nbits), .out_last(out_last), .ovf(ovf), .frame_cnt(frame_cnt)
   );

   int n_cmp = 0, n_fail = 0;

   // reference model: frame bits as a list, FIFO as a queue of finished entries
   bit   fb[$];
   logic [1:0] m_chan;
   bit   m_prev, m_ov, m_ovf;
   ent_t m_q[$];
   ent_t m_head;
   logic [7:0] m_fc;
   ent_t got[$];

   function automatic obs_t ob(logic v, logic [7:0] d, logic [1:0] c, logic [3:0] n, logic l, logic o, logic [7:0] f);
      return {v, d, c, n, l, o, f};
   endfunction

   function automatic obs_t dut_obs();
      return {out_valid, out_data, out_chan, out_nbits, out_last, ovf, frame_cnt};
   endfunction

   function automatic obs_t model_obs();
      return {m_ov, m_head, m_ovf, m_fc};
   endfunction

   function automatic ent_t mk(bit last);
      ent_t e;
      e.d = 8'd0;
      foreach (fb[i]) e.d = {e.d[6:0], fb[i]};
      e.c = m_chan;
      e.n = 4'(fb.size());
      e.l = last;
      return e;
   endfunction

   task automatic model_reset();
      fb.delete();
      m_q.delete();
      m_chan = 2'd0;
      m_prev = 0;
      m_ov = 0;
      m_ovf = 0;
      m_head = '0;
      m_fc = 8'd0;
   endtask

   task automatic model_edge(bit v, bit b, logic [1:0] c, bit r, bit cl);
      bit pop, psh, drop;
      int nb;
      ent_t pe;
      pop = m_ov && r;
      nb = m_q.size();
      psh = 0;
      drop = 0;
      pe = '0;
      if (v) begin
         if (fb.size() > 0 && c != m_chan) begin
            pe = mk(1); psh = 1; fb.delete(); m_fc++;
         end else if (fb.size() == 8) begin
            pe = mk(0); psh = 1; fb.delete();
         end
         if (fb.size() == 0) m_chan = c;
         fb.push_back(b);
      end else if (m_prev && fb.size() > 0) begin
         pe = mk(1); psh = 1; fb.delete(); m_fc++;
      end
      m_prev = v;
      if (pop) void'(m_q.pop_front());
      if (psh) begin
         if (nb < DEPTH || pop) m_q.push_back(pe);
         else drop = 1;
      end
      m_ov = (nb - int'(pop)) > 0;
      if (m_ov) m_head = m_q[0];
      m_ovf = drop ? 1'b1 : cl ? 1'b0 : m_ovf;
   endtask

   task automatic chk(string nm, logic [31:0] g, logic [31:0] x);
      n_cmp++;
      if (g !== x) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", nm, g, x);
      end
   endtask

   task automatic step(bit v, bit b, logic [1:0] c, bit r, bit cl);
      in_valid = v; in_bit = b; in_chan = c; out_ready = r; clr_ovf = cl;
      #1;
      if (out_valid && r) got.push_back({out_data, out_chan, out_nbits, out_last});
      @(posedge clk);
      model_edge(v, b, c, r, cl);
      #1;
      chk("model", 32'(dut_obs()), 32'(model_obs()));
   endtask

   vec_t tbl[19];
   bit   b1[8] = '{1, 0, 1, 1, 0, 0, 1, 0};
   bit   b2[11] = '{1, 0, 1, 0, 1, 0, 1, 0, 1, 1, 1};

   initial begin
      logic [1:0] rc;
      for (int i = 0; i < 8; i++) tbl[i] = '{1, b1[i], 2'd2, 0, ob(0, 8'h00, 0, 0, 0, 0, 0)};
      tbl[8]  = '{0, 0, 0, 0, ob(0, 8'h00, 0, 0, 0, 0, 1)};
      tbl[9]  = '{0, 0, 0, 0, ob(1, 8'hB2, 2, 8, 1, 0, 1)};
      tbl[10] = '{0, 0, 0, 1, ob(0, 8'hB2, 2, 8, 1, 0, 1)};
      tbl[11] = '{1, 1, 0, 1, ob(0, 8'hB2, 2, 8, 1, 0, 1)};
      tbl[12] = '{1, 1, 0, 1, ob(0, 8'hB2, 2, 8, 1, 0, 1)};
      tbl[13] = '{1, 0, 0, 1, ob(0, 8'hB2, 2, 8, 1, 0, 1)};
      tbl[14] = '{1, 0, 3, 1, ob(0, 8'hB2, 2, 8, 1, 0, 2)};
      tbl[15] = '{1, 1, 3, 1, ob(1, 8'h06, 0, 3, 1, 0, 2)};
      tbl[16] = '{0, 0, 0, 1, ob(0, 8'h06, 0, 3, 1, 0, 3)};
      tbl[17] = '{0, 0, 0, 1, ob(1, 8'h01, 3, 2, 1, 0, 3)};
      tbl[18] = '{0, 0, 0, 1, ob(0, 8'h01, 3, 2, 1, 0, 3)};
      model_reset();
      #11;
      chk("reset", 32'(dut_obs()), 32'(0));
      rst = 1'b0;
      for (int i = 0; i < 19; i++) begin
         step(tbl[i].v, tbl[i].b, tbl[i].c, tbl[i].r, 0);
         chk($sformatf("table[%0d]", i), 32'(dut_obs()), 32'(tbl[i].x));
      end
      // 11-bit frame: a full byte followed by a 3-bit tail
      got.delete();
      for (int i = 0; i < 11; i++) step(1, b2[i], 2'd1, 1, 0);
      for (int i = 0; i < 5; i++) step(0, 0, 0, 1, 0);
      chk("frame11_count", 32'(got.size()), 32'd2);
      chk("frame11_byte0", 32'(got[0]), 32'({8'hAA, 2'd1, 4'd8, 1'b0}));
      chk("frame11_byte1", 32'(got[1]), 32'({8'h07, 2'd1, 4'd3, 1'b1}));
      // overflow: five single-bit frames into a stalled FIFO
      got.delete();
      for (int i = 0; i < 5; i++) begin
         step(1, i[0], 2'(i), 0, 0);
         step(0, 0, 0, 0, 0);
      end
      chk("ovf_set", 32'(ovf), 32'd1);
      step(0, 0, 0, 0, 1);
      chk("ovf_clear", 32'(ovf), 32'd0);
      for (int i = 0; i < 8; i++) step(0, 0, 0, 1, 0);
      chk("drain_count", 32'(got.size()), 32'd4);
      for (int i = 0; i < 4; i++)
         chk($sformatf("drain[%0d]", i), 32'(got[i]), 32'({7'd0, i[0], 2'(i), 4'd1, 1'b1}));
      // full FIFO: push and pop on the same edge must not drop
      for (int i = 0; i < 4; i++) begin
         step(1, 1, 2'(i), 0, 0);
         step(0, 0, 0, 0, 0);
      end
      got.delete();
      step(1, 0, 2'd2, 0, 0);
      step(0, 0, 0, 1, 0);
      chk("full_pushpop_ovf", 32'(ovf), 32'd0);
      for (int i = 0; i < 8; i++) step(0, 0, 0, 1, 0);
      chk("full_pushpop_count", 32'(got.size()), 32'd5);
      chk("full_pushpop_tail", 32'(got[4]), 32'({8'h00, 2'd2, 4'd1, 1'b1}));
      // asynchronous reset mid-frame
      for (int i = 0; i < 5; i++) step(1, 1, 2'd2, 0, 0);
      #2 rst = 1'b1;
      #1 chk("async_reset", 32'(dut_obs()), 32'(0));
      model_reset();
      @(negedge clk);
      rst = 1'b0;
      got.delete();
      step(1, 1, 2'd1, 1, 0);
      step(1, 1, 2'd1, 1, 0);
      for (int i = 0; i < 5; i++) step(0, 0, 0, 1, 0);
      chk("post_reset_count", 32'(got.size()), 32'd1);
      chk("post_reset_entry", 32'(got[0]), 32'({8'h03, 2'd1, 4'd2, 1'b1}));
      // random traffic
      rc = 2'd0;
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 15) == 0) rc = 2'($urandom);
         step($urandom_range(0, 9) < 7, 1'($urandom), rc, 1'($urandom), $urandom_range(0, 31) == 0);
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule
